// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline-side request/ack signals and memory-macro signals of the port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_rdata;
  logic              if_ack;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              stall_if;
  logic              stall_mem;
  logic              halted;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_rdata, if_ack, mem_rdata, mem_ack, stall_if, stall_mem, halted,
           ram_en, ram_we, ram_addr, ram_wdata
  );
  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_rdata, if_ack, mem_rdata, mem_ack, stall_if, stall_mem, halted,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data access (data first),
// running each access through issue/wait/done and latching the all-ones halt marker.
module mem_port_arbiter #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 10
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              own_q, own_d, we_q, we_d, halted_q, halted_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ram_addr_q, ram_addr_d;
  logic [31:0]       wdata_q, wdata_d, ram_wdata_q, ram_wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d, mem_rdata_q, mem_rdata_d;
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic              if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
  logic              grant, halt_mark, capture, unused_addr_bits;

  assign grant            = state_q == IDLE && !halted_q && (bus.mem_req || bus.if_req);
  assign halt_mark        = bus.mem_req && !bus.mem_we && &bus.mem_addr;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0]};

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      own_q       <= 1'b0;
      we_q        <= 1'b0;
      halted_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_q       <= own_d;
      we_q        <= we_d;
      halted_q    <= halted_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end

  // The halt marker skips the memory entirely and acks straight from IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    own_d    = own_q;
    we_d     = we_q;
    halted_d = halted_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    capture  = 1'b0;
    case (state_q)
      IDLE: if (grant) begin
        own_d    = bus.mem_req;
        we_d     = bus.mem_req && bus.mem_we;
        addr_d   = bus.mem_req ? bus.mem_addr[ADDR_W+1:2] : bus.if_addr[ADDR_W+1:2];
        wdata_d  = bus.mem_req ? bus.mem_wdata : '0;
        halted_d = halt_mark;
        state_d  = halt_mark ? DONE : ISSUE;
      end
      ISSUE: begin
        cnt_d   = 4'(LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        capture = cnt_q == 4'd0 && !we_q;
        cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
        state_d = cnt_q == 4'd0 ? DONE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_en_d    = state_d == ISSUE;
    ram_we_d    = state_d == ISSUE && we_d;
    ram_addr_d  = state_d == ISSUE ? addr_d : ram_addr_q;
    ram_wdata_d = state_d == ISSUE ? wdata_d : ram_wdata_q;
    if_ack_d    = state_d == DONE && !own_d;
    mem_ack_d   = state_d == DONE && own_d;
    if_rdata_d  = capture && !own_q ? bus.ram_rdata : if_rdata_q;
    mem_rdata_d = capture && own_q ? bus.ram_rdata : mem_rdata_q;
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.mem_ack   = mem_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.halted    = halted_q;
  assign bus.stall_if  = bus.if_req && !if_ack_q;
  assign bus.stall_mem = bus.mem_req && !mem_ack_q;
endmodule
